custom_ahb_param_decoder: RTL
=============================

# custom_ahb_param_decoder

Parametrised per-input-port address decoder for the custom AHB bus matrix, the generalised successor of the fixed per-slave-interface decoders. It maps the input stage's address-phase request onto one of `NUM_PORTS` bus-switch outputs using parameter-supplied address regions, and steers the data-phase ready, response and read data back from the selected output. Unmapped accesses go to an integrated two-cycle ERROR default slave. An optional capture unit records decode errors.

## Interface
- `NUM_PORTS`, 5: number of bus-switch outputs (1..16).
- `REGION_BASE`, packed `22*NUM_PORTS` bits, all zero: per-port inclusive lower bound on `decode_addr_dec[31:10]`; port i occupies slice `[22*i+21:22*i]`.
- `REGION_LIMIT`, packed `22*NUM_PORTS` bits, all zero: per-port inclusive upper bound on `decode_addr_dec[31:10]`, same slicing.
- `HCLK` in 1: AHB clock.
- `HRESET` in 1: reset, synchronous and active-high.
- `HREADYS` in 1: input-stage HREADY (transfer done).
- `sel_dec` in 1: input-stage HSEL.
- `decode_addr_dec` in 22 `[31:10]`: address-phase HADDR bits used for decode.
- `trans_dec` in 2: HTRANS.
- `active_dec_i` in `NUM_PORTS`: per-output active flags.
- `readyout_dec_i` in `NUM_PORTS`: per-output HREADYOUT.
- `resp_dec_i` in `2*NUM_PORTS`: per-output HRESP.
- `rdata_dec_i` in `32*NUM_PORTS`: per-output HRDATA.
- `sel_dec_o` out `NUM_PORTS`: one-hot HSEL to the outputs.
- `active_dec` out 1: active flag of the address-phase target.
- `HREADYOUTS` out 1: data-phase ready.
- `HRESPS` out 2: data-phase response.
- `HRDATAS` out 32: data-phase read data.
- `err_valid` out 1: only with `CUSTOM_DEC_ERR_CAPTURE_EN`; a decode error has been captured.
- `err_addr` out 22: only with `CUSTOM_DEC_ERR_CAPTURE_EN`; address of the last error.
- `err_count` out 16: only with `CUSTOM_DEC_ERR_CAPTURE_EN`; count of decode errors.

## Operation
- **Address decode** (combinational), lowest index wins on region overlap:
  - Port i hits when `REGION_BASE[i] <= decode_addr_dec <= REGION_LIMIT[i]`, unsigned.
  - Port i also hits when `trans_dec == IDLE` and `data_port == i`. This keeps an idle bus parked on its current port.
  - No hit selects the default slave, with internal index `DFT = NUM_PORTS`.
- **Select outputs:**
  - `sel_dec_o[i] = sel_dec & (addr_port == i)`.
  - The default slave HSEL is `sel_dec & (addr_port == DFT)`.
- **Active flag:** `active_dec = active_dec_i[addr_port]`; it is 1 when `addr_port == DFT`.
- **Data-phase register:** `data_port` loads `addr_port` when `HREADYS` is 1 and holds otherwise. Width is `$clog2(NUM_PORTS+1)`.
- **Data-phase mux:** `HREADYOUTS`, `HRESPS` and `HRDATAS` come from output `data_port`. When `data_port == DFT`, they come from the default slave and `HRDATAS = 0`.
- **Default slave FSM**, states IDLE, ERR1, ERR2:
  - IDLE → ERR1 when its HSEL & `HREADYS` & `trans_dec[1]` (NONSEQ/SEQ).
  - ERR1 → ERR2 unconditionally.
  - ERR2 → ERR1 if the same qualifying condition holds, else IDLE.
  - Outputs in IDLE: ready = 1, resp = OKAY.
  - Outputs in ERR1: ready = 0, resp = ERROR.
  - Outputs in ERR2: ready = 1, resp = ERROR.
  - IDLE/BUSY transfers to the default slave get a zero-wait OKAY.

## Timing
- Address phase to sel/active: 0 cycles (combinational).
- Data-phase mux follows `data_port`, which updates on the HCLK edge where `HREADYS` is 1.
- A default-slave error takes exactly 2 data-phase cycles. The first cycle has `HREADYOUTS` = 0.
- **Reset** (`HRESET` high at a rising edge):
  - `data_port` = DFT and the FSM goes to IDLE.
  - Resulting outputs: `HREADYOUTS` = 1, `HRESPS` = 00, `HRDATAS` = 0.
  - Capture regs reset to `err_valid` = 0, `err_addr` = 0, `err_count` = 0.
  - Reset takes effect mid-ERR1/ERR2: the error is abandoned and the next cycle is IDLE.
- `HREADYS` low holds `data_port` and the FSM state except for the ERR1 → ERR2 advance, which ignores `HREADYS`.
- A back-to-back error (new NONSEQ in ERR2 with `HREADYS` = 1) goes directly to ERR1.

## Configuration
- `CUSTOM_DEC_ERR_CAPTURE_EN` defined: capture unit is present.
  - It acts on every IDLE → ERR1 or ERR2 → ERR1 transition.
  - On each such transition it sets `err_valid`, loads `err_addr` with `decode_addr_dec`, and increments `err_count`.
  - `err_count` saturates at 0xFFFF.
  - Capture values are sticky until `HRESET`.
- `CUSTOM_DEC_ERR_CAPTURE_EN` undefined: the three `err_*` ports and the capture logic do not exist.

## Structure
- Package `custom_ahb_pkg` holds:
  - HTRANS encodings IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
  - HRESP encodings OKAY=00, ERROR=01.
  - The default-slave state typedef.
- Sub-module `custom_ahb_param_default_slave` holds the three-state FSM; it is instantiated once.

## Test plan
- **Region hit:** `NUM_PORTS`=3, regions {0x080000–0x08001F, 0x140000–0x14012C, 0x100200–0x100203}; NONSEQ to `decode_addr_dec`=0x140010 with `sel_dec`=1 → `sel_dec_o`=3'b010 the same cycle. Next cycle `HRDATAS`=`rdata_dec_i[63:32]`.
- **Unmapped access:** NONSEQ to 0x200000 → `sel_dec_o`=0 and `active_dec`=1. Data phase gives `HREADYOUTS` 0 then 1, with `HRESPS`=01 on both cycles and `HRDATAS`=0.
- **Idle parking:** after a port-2 transfer, IDLE with an unmapped address → `sel_dec_o[2]`=1 and no error.
- **Overlap priority:** ports 0 and 1 both cover 0x080010 → only `sel_dec_o[0]`=1.
- **Wait state:** `readyout_dec_i[1]`=0 for 3 cycles → `HREADYOUTS`=0 for those 3 cycles and `data_port` holds.
- **Reset and capture:** assert `HRESET` during ERR1 → next cycle `HREADYOUTS`=1 and `HRESPS`=00. With `CUSTOM_DEC_ERR_CAPTURE_EN`, two errors to 0x3FFFFF → `err_count`=2 and `err_addr`=0x3FFFFF.

Source files
------------

// File: rtl/custom_ahb_pkg.sv
// Shared encodings for the custom AHB bus-matrix decoder:
// HTRANS / HRESP codes, default-slave state type and a transfer qualifier.
package custom_ahb_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HRESP encodings
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Default (ERROR) slave states
    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } dft_state_e;

    // True for transfers that carry data (NONSEQ/SEQ); IDLE/BUSY get a
    // zero-wait OKAY from any slave, including the default one.
    function automatic logic trans_is_xfer(input logic [1:0] trans);
        logic xfer;
        case (trans)
            HTRANS_IDLE,
            HTRANS_BUSY:   xfer = 1'b0;
            HTRANS_NONSEQ,
            HTRANS_SEQ:    xfer = 1'b1;
            default:       xfer = 1'b0;
        endcase
        return xfer;
    endfunction

endpackage

// File: rtl/custom_ahb_param_default_slave.sv
// Two-cycle ERROR default slave for unmapped accesses.
// Optional macro CUSTOM_DEC_ERR_CAPTURE_EN adds the err_start strobe that
// marks every entry into ERR1 (new error accepted).
module custom_ahb_param_default_slave
    import custom_ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       hsel,
    input  logic       ready_in,
    input  logic [1:0] trans,
    output logic       ready,
    output logic [1:0] resp
`ifdef CUSTOM_DEC_ERR_CAPTURE_EN
    ,
    output logic       err_start
`endif
);

    dft_state_e state;
    dft_state_e state_next;
    logic       qualify;

    assign qualify = hsel && ready_in && trans_is_xfer(trans);

    // State register; synchronous reset abandons any error in flight.
    always_ff @(posedge HCLK) begin
        if (HRESET) state <= DS_IDLE;
        else        state <= state_next;
    end

    // Next-state and Moore outputs. ERR1 always advances (it is the wait
    // cycle the slave itself inserts); ERR2 holds while the bus stalls.
    always_comb begin
        state_next = state;
        ready      = 1'b1;
        resp       = HRESP_OKAY;
        case (state)
            DS_IDLE: begin
                if (qualify) state_next = DS_ERR1;
            end
            DS_ERR1: begin
                ready      = 1'b0;
                resp       = HRESP_ERROR;
                state_next = DS_ERR2;
            end
            DS_ERR2: begin
                resp = HRESP_ERROR;
                if (qualify)       state_next = DS_ERR1;
                else if (ready_in) state_next = DS_IDLE;
            end
            default: state_next = DS_IDLE;
        endcase
    end

`ifdef CUSTOM_DEC_ERR_CAPTURE_EN
    assign err_start = (state_next == DS_ERR1) && (state != DS_ERR1);
`endif

endmodule

// File: rtl/custom_ahb_param_decoder.sv
// Parametrised per-input-port address decoder for the custom AHB matrix.
// Decodes the address phase onto NUM_PORTS outputs (lowest index wins on
// overlap, idle bus parks on the current data-phase port), routes unmapped
// accesses to an integrated ERROR slave, and muxes the data-phase response
// back from the selected output.
// Optional macro CUSTOM_DEC_ERR_CAPTURE_EN adds the decode-error capture unit
// (err_valid / err_addr / err_count).
module custom_ahb_param_decoder
    import custom_ahb_pkg::*;
#(
    parameter int                      NUM_PORTS    = 5,
    parameter logic [22*NUM_PORTS-1:0] REGION_BASE  = '0,
    parameter logic [22*NUM_PORTS-1:0] REGION_LIMIT = '0
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     HREADYS,
    input  logic                     sel_dec,
    input  logic [31:10]             decode_addr_dec,
    input  logic [1:0]               trans_dec,
    input  logic [NUM_PORTS-1:0]     active_dec_i,
    input  logic [NUM_PORTS-1:0]     readyout_dec_i,
    input  logic [2*NUM_PORTS-1:0]   resp_dec_i,
    input  logic [32*NUM_PORTS-1:0]  rdata_dec_i,
    output logic [NUM_PORTS-1:0]     sel_dec_o,
    output logic                     active_dec,
    output logic                     HREADYOUTS,
    output logic [1:0]               HRESPS,
    output logic [31:0]              HRDATAS
`ifdef CUSTOM_DEC_ERR_CAPTURE_EN
    ,
    output logic                     err_valid,
    output logic [21:0]              err_addr,
    output logic [15:0]              err_count
`endif
);

    // Port index width covers the extra default-slave index DFT.
    localparam int            DW  = $clog2(NUM_PORTS + 1);
    localparam logic [DW-1:0] DFT = DW'(NUM_PORTS);

    logic [DW-1:0]        addr_port;
    logic [DW-1:0]        data_port;
    logic [NUM_PORTS-1:0] hit;
    logic                 idle_bus;
    logic                 dft_sel;
    logic                 dft_ready;
    logic [1:0]           dft_resp;
`ifdef CUSTOM_DEC_ERR_CAPTURE_EN
    logic                 err_start;
`endif

    assign idle_bus = (trans_dec == HTRANS_IDLE);

    // Per-port region compare plus idle parking on the current data port.
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        logic [21:0] base;
        logic [21:0] limit;
        assign base  = REGION_BASE[22*g +: 22];
        assign limit = REGION_LIMIT[22*g +: 22];

        assign hit[g] = ((decode_addr_dec >= base) && (decode_addr_dec <= limit))
                      || (idle_bus && (data_port == DW'(g)));

        assign sel_dec_o[g] = sel_dec && (addr_port == DW'(g));
    end

    // Priority encode: scan downward so the lowest hitting index survives.
    always_comb begin
        addr_port = DFT;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (hit[i]) addr_port = DW'(i);
        end
    end

    assign dft_sel = sel_dec && (addr_port == DFT);

    // Active flag of the address-phase target; the default slave is always active.
    always_comb begin
        active_dec = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_port == DW'(i)) active_dec = active_dec_i[i];
        end
    end

    // Data-phase port register; advances only when the current transfer completes.
    always_ff @(posedge HCLK) begin
        if (HRESET)       data_port <= DFT;
        else if (HREADYS) data_port <= addr_port;
    end

    // Data-phase response mux; default slave returns zero read data.
    always_comb begin
        HREADYOUTS = dft_ready;
        HRESPS     = dft_resp;
        HRDATAS    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_port == DW'(i)) begin
                HREADYOUTS = readyout_dec_i[i];
                HRESPS     = resp_dec_i[2*i +: 2];
                HRDATAS    = rdata_dec_i[32*i +: 32];
            end
        end
    end

    custom_ahb_param_default_slave u_dft (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .hsel      (dft_sel),
        .ready_in  (HREADYS),
        .trans     (trans_dec),
        .ready     (dft_ready),
        .resp      (dft_resp)
`ifdef CUSTOM_DEC_ERR_CAPTURE_EN
        ,
        .err_start (err_start)
`endif
    );

`ifdef CUSTOM_DEC_ERR_CAPTURE_EN
    // Sticky capture of decode errors; the counter saturates rather than wraps.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else if (err_start) begin
            err_valid <= 1'b1;
            err_addr  <= decode_addr_dec;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule
